mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the CPU's single memory port (readM / writeM / address / data) between the CPU memory interface and a DMA-style secondary requester. It sits between the `cpu` top level and the memory model, replacing the direct connection. It serializes accesses through a fixed-latency access window, uses round-robin ordering on contention, and returns a one-cycle acknowledge plus read data to the winning requester.

## Interface
Parameters:
- `WORD_SIZE`, 16: address and data width.
- `MEM_LATENCY`, 2: cycles readM/writeM are held per access. Must be ≥1.

Ports:
- `clk`  in  1  the single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `c_req`  in  1  CPU access request; held high until `c_ack`.
- `c_write`  in  1  CPU access type: 1 = write, 0 = read.
- `c_addr`  in  WORD_SIZE  CPU address.
- `c_wdata`  in  WORD_SIZE  CPU write data.
- `c_ack`  out  1  one-cycle completion pulse to the CPU.
- `c_rdata`  out  WORD_SIZE  CPU read data, registered.
- `d_req`, `d_write`, `d_addr`, `d_wdata`, `d_ack`, `d_rdata`: same as the `c_` ports, for the DMA requester.
- `readM`  out  1  memory read strobe.
- `writeM`  out  1  memory write strobe.
- `address`  out  WORD_SIZE  memory address.
- `data`  inout  WORD_SIZE  memory data bus; driven only during a write access, Z otherwise.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `owner`  out  1  current or most recent grantee: 0 = CPU, 1 = DMA.

## Operation
The FSM has three states: IDLE, ACCESS, DONE. Internal registers are `cnt` (counter), `last` (last-served requester) and a latched transaction (`wr`, `addr`, `wdata`, `owner`).

- **IDLE**
  - No request: stay in IDLE.
  - Exactly one `*_req` high: grant that requester.
  - Both high: grant the requester that is not `last`.
  - On grant, latch the requester's write/addr/wdata and set `owner`. Set `cnt` = MEM_LATENCY-1 and go to ACCESS.
- **ACCESS**
  - `address` = latched addr.
  - `readM` = !wr and `writeM` = wr.
  - `data` = latched wdata when wr, else Z.
  - Each edge with `cnt`≠0 decrements `cnt`.
  - The edge with `cnt`==0:
    - for a read, captures `data` into the owner's rdata register;
    - goes to DONE.
- **DONE**
  - The owner's `*_ack` = 1 for this single cycle.
  - `readM`, `writeM` = 0 and `data` = Z.
  - On the edge, set `last` = `owner` and go to IDLE.
- **Outside ACCESS**: `readM`, `writeM` = 0, `address` = 0, `data` = Z.
- **Request changes**: requester inputs are sampled only at the grant edge. Changes during ACCESS/DONE are ignored. A `*_req` dropped mid-transaction does not cancel it; the ack still pulses once.
- **Back-to-back**: a `*_req` still high in IDLE after DONE is a new request. Requesters must drop `req` in the cycle after ack unless they want another access.
- **Read data**: `*_rdata` holds its value until that requester's next read completes. Writes leave `*_rdata` unchanged.
- **Tie-break at start-up**: `last` resets to 1, so the CPU wins the first tie.

## Timing
- **Reset (asynchronous, immediate)**
  - state = IDLE, `cnt` = 0, `last` = 1, `owner` = 0.
  - `readM` = `writeM` = 0, `address` = 0, `data` = Z.
  - `c_ack` = `d_ack` = 0, `c_rdata` = `d_rdata` = 0, `busy` = 0.
- **Reset mid-ACCESS**: aborts the access. Strobes drop immediately, no ack is issued and rdata is not updated.
- **Latency**, for a request sampled at edge E0 in IDLE:
  - ACCESS occupies cycles E0+1 … E0+MEM_LATENCY;
  - ack is high in cycle E0+MEM_LATENCY+1;
  - rdata is valid in the same cycle as ack.
- **Throughput**: one access per MEM_LATENCY+2 cycles. The IDLE cycle between transactions is mandatory.
- **Read data**: the memory must present valid `data` by the final ACCESS edge.
- **Output registering**: `readM`, `writeM`, `address`, `busy` and `*_ack` are decoded from registered state only, with no combinational path from `*_req`.

## Test plan
All scenarios use MEM_LATENCY = 2.
1. **Reset**: pulse `reset` with requests active → all outputs 0, `data` = Z, `busy` = 0. After release, the first tie goes to the CPU.
2. **CPU read**: `c_req`=1, `c_write`=0, `c_addr`=0x0010; memory returns 0x1234 → `readM`=1 with `address`=0x0010 for 2 cycles, then `c_ack` pulses for 1 cycle with `c_rdata`=0x1234. `d_ack` stays 0.
3. **DMA write**: `d_write`=1, `d_addr`=0x0020, `d_wdata`=0xBEEF → `writeM`=1 and `data`=0xBEEF for 2 cycles, then `d_ack` pulses. `data` returns to Z; `d_rdata` is unchanged.
4. **Contention**: `c_req` and `d_req` held high continuously → grants alternate CPU, DMA, CPU, DMA. Ack pulses are 4 cycles apart; `owner` toggles 0,1,0,1.
5. **Reset mid-access**: assert `reset` in the first ACCESS cycle of a CPU read → `readM` falls immediately, `c_ack` never pulses, `c_rdata` = 0. After release the FSM is in IDLE with `busy` = 0.
6. **Request dropped mid-access**: drop `c_req` during ACCESS → `c_ack` still pulses exactly once and no second transaction starts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one fixed-latency memory port between a CPU and a DMA engine.
// Round-robin on contention; one-cycle ack plus registered read data back to the winner.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_req,
  input  logic                 c_write,
  input  logic [WORD_SIZE-1:0] c_addr,
  input  logic [WORD_SIZE-1:0] c_wdata,
  output logic                 c_ack,
  output logic [WORD_SIZE-1:0] c_rdata,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic                 owner
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]  c_rdata_q, c_rdata_d;
  logic [WORD_SIZE-1:0]  d_rdata_q, d_rdata_d;
  logic                  grant_dma;
  logic                  in_access;

  // On a tie the requester that was not served last wins.
  assign grant_dma = d_req & (~c_req | ~last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (c_req || d_req) begin
          owner_d = grant_dma;
          wr_d    = grant_dma ? d_write : c_write;
          addr_d  = grant_dma ? d_addr  : c_addr;
          wdata_d = grant_dma ? d_wdata : c_wdata;
          cnt_d   = CntW'(MEM_LATENCY - 1);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          if (!wr_q) begin
            if (owner_q) d_rdata_d = data;
            else         c_rdata_d = data;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All memory-side outputs decode from registered state only.
  assign in_access = (state_q == StAccess);
  assign readM     = in_access & ~wr_q;
  assign writeM    = in_access & wr_q;
  assign address   = in_access ? addr_q : '0;
  assign data      = (in_access && wr_q) ? wdata_q : {WORD_SIZE{1'bz}};
  assign busy      = (state_q != StIdle);
  assign c_ack     = (state_q == StDone) & ~owner_q;
  assign d_ack     = (state_q == StDone) & owner_q;
  assign owner     = owner_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model with its own copy of memory.
module tb_mem_port_arbiter;

  localparam int W = 16;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         c_req = 1'b0, c_write = 1'b0, d_req = 1'b0, d_write = 1'b0;
  logic [W-1:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic         c_ack, d_ack, readM, writeM, busy, owner;
  logic [W-1:0] c_rdata, d_rdata, address;
  wire  [W-1:0] data;

  logic [W-1:0] mem     [256];
  logic [W-1:0] mdl_mem [256];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Transaction-level model: one active access, its grant edge index and latched fields.
  bit           m_act = 1'b0;
  bit           m_last = 1'b1;
  bit           m_own = 1'b0;
  bit           m_wr = 1'b0;
  logic [W-1:0] m_addr = '0, m_wd = '0;
  logic [W-1:0] m_rd [2];
  int           n = 0, m_g = 0;

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory device: drives the bus while reading, stores on every edge with writeM high.
  assign data = readM ? mem[address[7:0]] : 'z;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (writeM) mem[address[7:0]] <= data;
    end
  end

  // Reference model: grant at edge g -> access cycles g..g+L-1, ack cycle g+L, idle from g+L+1.
  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
    m_rd[0] = '0;
    m_rd[1] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_act = 1'b0; m_last = 1'b1; m_own = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0; n = 0;
      end else begin
        n++;
        if (m_act) begin
          if (m_wr && n >= m_g + 1 && n <= m_g + L) mdl_mem[m_addr[7:0]] = m_wd;
          if (!m_wr && n == m_g + L) m_rd[m_own] = mdl_mem[m_addr[7:0]];
          if (n == m_g + L + 1) begin
            m_act  = 1'b0;
            m_last = m_own;
          end
        end else if (c_req || d_req) begin
          m_own  = (c_req && d_req) ? !m_last : d_req;
          m_wr   = m_own ? d_write : c_write;
          m_addr = m_own ? d_addr : c_addr;
          m_wd   = m_own ? d_wdata : c_wdata;
          m_g    = n;
          m_act  = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    bit acc, dn;
    forever begin
      @(negedge clk);
      if (started) begin
        acc = m_act && n >= m_g && n <= m_g + L - 1;
        dn  = m_act && n == m_g + L;
        chk("readM",   32'(readM),   32'(acc && !m_wr));
        chk("writeM",  32'(writeM),  32'(acc && m_wr));
        chk("address", 32'(address), acc ? 32'(m_addr) : 32'd0);
        chk("busy",    32'(busy),    32'(m_act));
        chk("c_ack",   32'(c_ack),   32'(dn && !m_own));
        chk("d_ack",   32'(d_ack),   32'(dn && m_own));
        chk("owner",   32'(owner),   32'(m_own));
        chk("c_rdata", 32'(c_rdata), 32'(m_rd[0]));
        chk("d_rdata", 32'(d_rdata), 32'(m_rd[1]));
        if (acc && m_wr)  chk("data_wr", 32'(data), 32'(m_wd));
        if (acc && !m_wr) chk("data_rd", 32'(data), 32'(mdl_mem[m_addr[7:0]]));
      end
    end
  end

  initial begin
    int cnt_a, cnt_b, cnt_c, nacks, cyc;
    logic [W-1:0] saved;
    bit owners [4];
    int ackcyc [4];

    // Reset with both requests active, then first tie goes to the CPU; drop both mid-access.
    #2;
    c_write = 1'b0; c_addr = 16'h0030; d_write = 1'b0; d_addr = 16'h0040;
    c_req = 1'b1; d_req = 1'b1; reset = 1'b1; started = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_readM", 32'(readM), 32'd0);
    chk("rst_writeM", 32'(writeM), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({c_ack, d_ack}), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("tie_owner", 32'(owner), 32'd0);
    chk("tie_busy", 32'(busy), 32'd1);
    c_req = 1'b0; d_req = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt_a += int'(c_ack);
      cnt_b += int'(d_ack);
    end
    chk("drop_c_ack_count", 32'(cnt_a), 32'd1);
    chk("drop_d_ack_count", 32'(cnt_b), 32'd0);
    chk("drop_rdata", 32'(c_rdata), 32'(init_val(16'h30)));
    chk("drop_idle", 32'(busy), 32'd0);

    // CPU read of 0x0010.
    tick();
    c_req = 1'b1; c_write = 1'b0; c_addr = 16'h0010;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; saved = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (readM && address == 16'h0010) cnt_a++;
      cnt_c += int'(d_ack);
      if (c_ack) begin
        cnt_b++;
        saved = c_rdata;
        c_req = 1'b0;
      end
    end
    chk("cpu_read_cycles", 32'(cnt_a), 32'd2);
    chk("cpu_read_acks", 32'(cnt_b), 32'd1);
    chk("cpu_read_data", 32'(saved), 32'h1234);
    chk("cpu_read_no_dack", 32'(cnt_c), 32'd0);

    // DMA write of 0xBEEF to 0x0020.
    tick();
    saved = d_rdata;
    d_req = 1'b1; d_write = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (writeM && address == 16'h0020 && data == 16'hBEEF) cnt_a++;
      if (d_ack) begin
        cnt_b++;
        d_req = 1'b0;
      end
    end
    chk("dma_write_cycles", 32'(cnt_a), 32'd2);
    chk("dma_write_acks", 32'(cnt_b), 32'd1);
    chk("dma_write_rdata", 32'(d_rdata), 32'(saved));
    chk("dma_write_mem", 32'(mem[8'h20]), 32'hBEEF);

    // Contention: both held high, grants must alternate starting with the CPU.
    tick();
    c_req = 1'b1; c_write = 1'b0; c_addr = 16'h0011;
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h0021;
    nacks = 0; cyc = 0;
    while (nacks < 4 && cyc < 40) begin
      @(negedge clk);
      if (c_ack || d_ack) begin
        owners[nacks] = d_ack;
        ackcyc[nacks] = cyc;
        nacks++;
      end
      cyc++;
    end
    c_req = 1'b0; d_req = 1'b0;
    chk("rr_ack_count", 32'(nacks), 32'd4);
    if (nacks == 4) begin
      chk("rr_owner0", 32'(owners[0]), 32'd0);
      chk("rr_owner1", 32'(owners[1]), 32'd1);
      chk("rr_owner2", 32'(owners[2]), 32'd0);
      chk("rr_owner3", 32'(owners[3]), 32'd1);
      for (int i = 0; i < 3; i++) chk("rr_spacing", 32'(ackcyc[i+1] - ackcyc[i]), 32'd4);
    end
    repeat (4) tick();

    // Reset during the first access cycle of a CPU read.
    c_req = 1'b1; c_write = 1'b0; c_addr = 16'h0010;
    tick();
    chk("abort_readM_before", 32'(readM), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_readM_after", 32'(readM), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    c_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt_a += int'(c_ack);
    end
    chk("abort_no_ack", 32'(cnt_a), 32'd0);
    chk("abort_rdata", 32'(c_rdata), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int k = 0; k < 4000; k++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      if (c_ack && $urandom_range(0, 1) == 0) c_req = 1'b0;
      else if (c_req && $urandom_range(0, 9) == 0) c_req = 1'b0;
      else if ((!c_req && $urandom_range(0, 2) == 0) || c_ack || $urandom_range(0, 7) == 0) begin
        c_req   = 1'b1;
        c_write = 1'($urandom_range(0, 1));
        c_addr  = 16'($urandom_range(0, 255));
        c_wdata = 16'($urandom);
      end
      if (d_ack && $urandom_range(0, 1) == 0) d_req = 1'b0;
      else if (d_req && $urandom_range(0, 9) == 0) d_req = 1'b0;
      else if ((!d_req && $urandom_range(0, 2) == 0) || d_ack || $urandom_range(0, 7) == 0) begin
        d_req   = 1'b1;
        d_write = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
